// File: rtl/cv_pattern_gen.sv
// Test-pattern luminance generator for a composite-video raster.
// Pattern controls are shadowed at frame start so a frame is always drawn with one consistent setting.
module cv_pattern_gen #(
  parameter int MAX_PIXEL_H   = 1280,
  parameter int MAX_SCANLINES = 625,
  parameter int LUM_W         = 2,
  parameter int BLINK_SHIFT   = 5,
  localparam int XW = $clog2(MAX_PIXEL_H),
  localparam int YW = $clog2(MAX_SCANLINES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clk_en_pixel,
  input  logic             x_vis,
  input  logic [XW-1:0]    x_pos,
  input  logic [YW-1:0]    y_pos,
  input  logic             frame_start,
  input  logic [2:0]       mode,
  input  logic [2:0]       size_shift,
  input  logic [LUM_W-1:0] solid_level,
  input  logic             scroll_en,
  input  logic             blink_en,
  output logic [LUM_W-1:0] lum,
  output logic [2:0]       active_mode,
  output logic [15:0]      frame_cnt
);

  localparam logic [2:0] MODE_OFF      = 3'd0;
  localparam logic [2:0] MODE_CHECKERS = 3'd1;
  localparam logic [2:0] MODE_VBARS    = 3'd2;
  localparam logic [2:0] MODE_HBARS    = 3'd3;
  localparam logic [2:0] MODE_RAMP     = 3'd4;
  localparam logic [2:0] MODE_SOLID    = 3'd5;

  logic [2:0]       r_mode;
  logic [2:0]       r_size;
  logic [LUM_W-1:0] r_solid;
  logic             r_scroll;
  logic             r_blink;
  logic [XW-1:0]    r_x_off;
  logic [15:0]      r_frame_cnt;
  logic [LUM_W-1:0] r_lum;

  logic [XW-1:0]    w_x_eff;
  logic [LUM_W-1:0] w_xs;
  logic [LUM_W-1:0] w_ys;
  logic [LUM_W-1:0] w_pat;
  logic [LUM_W-1:0] w_lum_nxt;
  logic             w_frame_acc;

  assign w_frame_acc = en & frame_start;

  // Shadow controls, scroll offset and frame counter advance only on an accepted frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode      <= 3'd0;
      r_size      <= 3'd0;
      r_solid     <= {LUM_W{1'b0}};
      r_scroll    <= 1'b0;
      r_blink     <= 1'b0;
      r_x_off     <= {XW{1'b0}};
      r_frame_cnt <= 16'd0;
    end else if (w_frame_acc) begin
      r_mode      <= mode;
      r_size      <= size_shift;
      r_solid     <= solid_level;
      r_scroll    <= scroll_en;
      r_blink     <= blink_en;
      r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_scroll) begin
        r_x_off <= r_x_off + XW'(1);
      end
    end
  end

  // Cell coordinates: only the low LUM_W bits of each shifted coordinate reach the output
  always_comb begin
    w_x_eff = x_pos + r_x_off;
    w_xs    = LUM_W'(w_x_eff >> r_size);
    w_ys    = LUM_W'(y_pos >> r_size);
  end

  // Pattern selection from the shadow mode, then frame-rate blink inversion
  always_comb begin
    w_pat     = {LUM_W{1'b0}};
    w_lum_nxt = {LUM_W{1'b0}};
    case (r_mode)
      MODE_OFF:      w_pat = {LUM_W{1'b0}};
      MODE_CHECKERS: w_pat = w_xs ^ {LUM_W{w_ys[0]}};
      MODE_VBARS:    w_pat = w_xs;
      MODE_HBARS:    w_pat = w_ys;
      MODE_RAMP:     w_pat = w_x_eff[XW-1 -: LUM_W];
      MODE_SOLID:    w_pat = r_solid;
      default:       w_pat = {LUM_W{1'b0}};
    endcase
    if (r_blink && r_frame_cnt[BLINK_SHIFT]) begin
      w_lum_nxt = ~w_pat;
    end else begin
      w_lum_nxt = w_pat;
    end
  end

  // Output register: disable forces black immediately, otherwise advance on pixel enables only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lum <= {LUM_W{1'b0}};
    end else if (!en) begin
      r_lum <= {LUM_W{1'b0}};
    end else if (clk_en_pixel) begin
      r_lum <= x_vis ? w_lum_nxt : {LUM_W{1'b0}};
    end
  end

  assign lum         = r_lum;
  assign active_mode = r_mode;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_cv_pattern_gen.sv
// Bench for cv_pattern_gen: directed scenarios plus randomized traffic against a
// frame-level behavioural model that evaluates the pattern rules arithmetically.
module tb_cv_pattern_gen;

  localparam int MAX_PIXEL_H   = 1280;
  localparam int MAX_SCANLINES = 625;
  localparam int LUM_W         = 2;
  localparam int BLINK_SHIFT   = 1;
  localparam int XW            = $clog2(MAX_PIXEL_H);
  localparam int YW            = $clog2(MAX_SCANLINES);
  localparam int XMOD          = 1 << XW;
  localparam int LMOD          = 1 << LUM_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic             clk_en_pixel = 1'b0;
  logic             x_vis = 1'b0;
  logic [XW-1:0]    x_pos = '0;
  logic [YW-1:0]    y_pos = '0;
  logic             frame_start = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic [2:0]       size_shift = 3'd0;
  logic [LUM_W-1:0] solid_level = '0;
  logic             scroll_en = 1'b0;
  logic             blink_en = 1'b0;
  logic [LUM_W-1:0] lum;
  logic [2:0]       active_mode;
  logic [15:0]      frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int m_mode, m_size, m_solid, m_scroll, m_blink, m_xoff, m_fcnt, m_lum;

  cv_pattern_gen #(
    .MAX_PIXEL_H(MAX_PIXEL_H), .MAX_SCANLINES(MAX_SCANLINES),
    .LUM_W(LUM_W), .BLINK_SHIFT(BLINK_SHIFT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clk_en_pixel(clk_en_pixel),
    .x_vis(x_vis), .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start),
    .mode(mode), .size_shift(size_shift), .solid_level(solid_level),
    .scroll_en(scroll_en), .blink_en(blink_en),
    .lum(lum), .active_mode(active_mode), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_size = 0; m_solid = 0; m_scroll = 0; m_blink = 0;
    m_xoff = 0; m_fcnt = 0; m_lum = 0;
  endtask

  function automatic int pat_of(int x, int y);
    int xe, xs, ys, p;
    xe = (x + m_xoff) % XMOD;
    xs = xe / (1 << m_size);
    ys = y / (1 << m_size);
    case (m_mode)
      1: p = (xs % LMOD) ^ (((ys % 2) == 1) ? (LMOD - 1) : 0);
      2: p = xs % LMOD;
      3: p = ys % LMOD;
      4: p = xe / (XMOD / LMOD);
      5: p = m_solid;
      default: p = 0;
    endcase
    if (m_blink == 1 && ((m_fcnt / (1 << BLINK_SHIFT)) % 2) == 1) p = (LMOD - 1) - p;
    return p;
  endfunction

  // one clk edge: predict from pre-edge state, then apply frame-start bookkeeping
  task automatic step();
    int nl;
    if (!en) nl = 0;
    else if (clk_en_pixel) nl = x_vis ? pat_of(int'(x_pos), int'(y_pos)) : 0;
    else nl = m_lum;
    if (en && frame_start) begin
      if (m_scroll == 1) m_xoff = (m_xoff + 1) % XMOD;
      m_fcnt   = (m_fcnt + 1) % 65536;
      m_mode   = int'(mode);
      m_size   = int'(size_shift);
      m_solid  = int'(solid_level);
      m_scroll = int'(scroll_en);
      m_blink  = int'(blink_en);
    end
    @(posedge clk);
    #1;
    m_lum = nl;
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1; clk_en_pixel = 1'b0;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pixel(input int x, input int y);
    x_pos = XW'(x); y_pos = YW'(y); clk_en_pixel = 1'b1; x_vis = 1'b1;
    step();
    clk_en_pixel = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) step();
    n_checks++;
    if (lum !== '0 || active_mode !== 3'd0 || frame_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_state: lum=%0d mode=%0d cnt=%0d expected 0/0/0", lum, active_mode, frame_cnt);
    end
    reset_n = 1'b1;
    en = 1'b1; mode = 3'd1; size_shift = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pixel(i + 1, 0);
      n_checks++;
      if (lum !== '0) begin
        n_errors++;
        $display("FAIL reset_no_fs: lum=%0d expected 0", lum);
      end
    end
  endtask

  task automatic test_checkers();
    int exp0 [4] = '{0, 1, 2, 3};
    int exp8 [4] = '{3, 2, 1, 0};
    do_reset();
    en = 1'b1; mode = 3'd1; size_shift = 3'd3;
    fs_pulse();
    for (int i = 0; i < 4; i++) begin
      pixel(8 * i, 0);
      n_checks++;
      if (lum !== LUM_W'(exp0[i]) || lum !== LUM_W'(m_lum)) begin
        n_errors++;
        $display("FAIL checkers_y0 x=%0d: lum=%0d expected %0d", 8 * i, lum, exp0[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      pixel(8 * i, 8);
      n_checks++;
      if (lum !== LUM_W'(exp8[i])) begin
        n_errors++;
        $display("FAIL checkers_y8 x=%0d: lum=%0d expected %0d", 8 * i, lum, exp8[i]);
      end
    end
  endtask

  task automatic test_midframe_mode();
    mode = 3'd2;
    pixel(8, 8);
    n_checks++;
    if (lum !== LUM_W'(2) || active_mode !== 3'd1) begin
      n_errors++;
      $display("FAIL midframe_hold: lum=%0d mode=%0d expected 2/1", lum, active_mode);
    end
    fs_pulse();
    pixel(8, 8);
    n_checks++;
    if (lum !== LUM_W'(1) || active_mode !== 3'd2) begin
      n_errors++;
      $display("FAIL midframe_next: lum=%0d mode=%0d expected 1/2", lum, active_mode);
    end
  endtask

  task automatic test_scroll();
    do_reset();
    en = 1'b1; mode = 3'd2; size_shift = 3'd0; scroll_en = 1'b1;
    repeat (3) fs_pulse();
    pixel(0, 0);
    n_checks++;
    if (lum !== LUM_W'(2)) begin
      n_errors++;
      $display("FAIL scroll_3rd_frame: lum=%0d expected 2", lum);
    end
    repeat (XMOD - 2) fs_pulse();
    pixel(0, 0);
    n_checks++;
    if (lum !== LUM_W'(0) || lum !== LUM_W'(m_lum)) begin
      n_errors++;
      $display("FAIL scroll_wrap: lum=%0d expected 0", lum);
    end
    pixel(5, 0);
    n_checks++;
    if (lum !== LUM_W'(1)) begin
      n_errors++;
      $display("FAIL scroll_wrap_x5: lum=%0d expected 1", lum);
    end
    n_checks++;
    if (frame_cnt !== 16'(XMOD + 1)) begin
      n_errors++;
      $display("FAIL scroll_frame_cnt: cnt=%0d expected %0d", frame_cnt, XMOD + 1);
    end
    scroll_en = 1'b0;
  endtask

  task automatic test_blink();
    int expv [4] = '{1, 2, 2, 1};
    do_reset();
    en = 1'b1; mode = 3'd5; solid_level = LUM_W'(1); blink_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      fs_pulse();
      pixel(3, 3);
      n_checks++;
      if (lum !== LUM_W'(expv[f]) || lum !== LUM_W'(m_lum)) begin
        n_errors++;
        $display("FAIL blink cnt=%0d: lum=%0d expected %0d", frame_cnt, lum, expv[f]);
      end
    end
    x_pos = XW'(3); clk_en_pixel = 1'b1; x_vis = 1'b0;
    step();
    clk_en_pixel = 1'b0;
    n_checks++;
    if (lum !== '0) begin
      n_errors++;
      $display("FAIL blank_xvis0: lum=%0d expected 0", lum);
    end
    blink_en = 1'b0;
  endtask

  task automatic test_coincide();
    do_reset();
    en = 1'b1; mode = 3'd2; size_shift = 3'd3;
    fs_pulse();
    mode = 3'd3; frame_start = 1'b1; clk_en_pixel = 1'b1; x_vis = 1'b1;
    x_pos = XW'(8); y_pos = YW'(16);
    step();
    frame_start = 1'b0;
    n_checks++;
    if (lum !== LUM_W'(1) || active_mode !== 3'd3) begin
      n_errors++;
      $display("FAIL coincide_old: lum=%0d mode=%0d expected 1/3", lum, active_mode);
    end
    step();
    clk_en_pixel = 1'b0;
    n_checks++;
    if (lum !== LUM_W'(2)) begin
      n_errors++;
      $display("FAIL coincide_new: lum=%0d expected 2", lum);
    end
  endtask

  task automatic test_async_reset_and_disable();
    do_reset();
    en = 1'b1; mode = 3'd5; solid_level = LUM_W'(3);
    fs_pulse();
    pixel(0, 0);
    n_checks++;
    if (lum !== LUM_W'(3)) begin
      n_errors++;
      $display("FAIL solid_level: lum=%0d expected 3", lum);
    end
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (lum !== '0 || frame_cnt !== 16'd0 || active_mode !== 3'd0) begin
      n_errors++;
      $display("FAIL async_reset: lum=%0d cnt=%0d mode=%0d expected 0/0/0", lum, frame_cnt, active_mode);
    end
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    en = 1'b0; mode = 3'd1;
    repeat (3) fs_pulse();
    pixel(8, 0);
    n_checks++;
    if (frame_cnt !== 16'd0 || lum !== '0 || active_mode !== 3'd0) begin
      n_errors++;
      $display("FAIL disabled: cnt=%0d lum=%0d mode=%0d expected 0/0/0", frame_cnt, lum, active_mode);
    end
    en = 1'b1;
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      en           = ($urandom % 16) != 0;
      clk_en_pixel = ($urandom % 3) == 0;
      x_vis        = ($urandom % 4) != 0;
      x_pos        = XW'($urandom_range(0, MAX_PIXEL_H - 1));
      y_pos        = YW'($urandom_range(0, MAX_SCANLINES - 1));
      frame_start  = ($urandom % 25) == 0;
      mode         = 3'($urandom % 8);
      size_shift   = 3'($urandom % 8);
      solid_level  = LUM_W'($urandom);
      scroll_en    = ($urandom % 4) != 0;
      blink_en     = ($urandom % 2) == 1;
      step();
      n_checks++;
      if (lum !== LUM_W'(m_lum) || active_mode !== 3'(m_mode) || frame_cnt !== 16'(m_fcnt)) begin
        n_errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random[%0d]: lum=%0d mode=%0d cnt=%0d expected %0d/%0d/%0d",
                   i, lum, active_mode, frame_cnt, m_lum, m_mode, m_fcnt);
        end
      end
    end
    frame_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_checkers();
    test_midframe_mode();
    test_scroll();
    test_blink();
    test_coincide();
    test_async_reset_and_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
